// File: rtl/regfile_pkg.sv
// regfile_pkg: shared FSM state type and default geometry for regfile_param
package regfile_pkg;
  typedef enum logic {IDLE, CLEAR} rf_state_t;
  localparam int RF_WIDTH = 16;
  localparam int RF_DEPTH = 8;
endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port: one read port (readnum -> data_out), out-of-range reads 0, optional same-cycle write bypass
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int WIDTH = RF_WIDTH,
  parameter int DEPTH = RF_DEPTH,
  parameter bit BYPASS = 1'b1,
  parameter int AW = 3
) (
  input  logic [AW-1:0]    readnum,
  input  logic [WIDTH-1:0] regs [DEPTH],
  input  logic             wr_ok,
  input  logic [AW-1:0]    writenum,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);
  always_comb data_out = (BYPASS && wr_ok && readnum == writenum) ? data_in :
                         (32'(readnum) < DEPTH) ? regs[readnum] : '0;
endmodule

// File: rtl/regfile_param.sv
// regfile_param: WIDTHxDEPTH 2R/1W register file; clk/reset, write port (data_in/writenum/write), read ports A/B, clear_req sweep with busy
module regfile_param
  import regfile_pkg::*;
#(
  parameter int WIDTH = RF_WIDTH,
  parameter int DEPTH = RF_DEPTH,
  parameter bit BYPASS = 1'b1,
  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AW-1:0]    writenum,
  input  logic             write,
  input  logic [AW-1:0]    readnum_a,
  input  logic [AW-1:0]    readnum_b,
  output logic [WIDTH-1:0] data_out_a,
  output logic [WIDTH-1:0] data_out_b,
  input  logic             clear_req,
  output logic             busy
);
  rf_state_t state, state_nxt;
  logic [AW-1:0] cnt;
  logic last, wr_ok;
  logic [WIDTH-1:0] regs [DEPTH];
  always_comb begin
    busy = state == CLEAR;
    last = 32'(cnt) == DEPTH - 1;
    wr_ok = write && !busy && 32'(writenum) < DEPTH;
    state_nxt = (state == IDLE) ? (clear_req ? CLEAR : IDLE) : (last ? IDLE : CLEAR);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt <= (busy && !last) ? cnt + AW'(1) : '0;
    end
  for (genvar i = 0; i < DEPTH; i++) begin : g_reg
    always_ff @(posedge clk or posedge reset)
      if (reset) regs[i] <= '0;
      else if (busy && 32'(cnt) == i) regs[i] <= '0;
      else if (wr_ok && 32'(writenum) == i) regs[i] <= data_in;
  end
  regfile_read_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BYPASS(BYPASS), .AW(AW)) u_rd_a (
    .readnum(readnum_a), .regs(regs), .wr_ok(wr_ok), .writenum(writenum),
    .data_in(data_in), .data_out(data_out_a)
  );
  regfile_read_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BYPASS(BYPASS), .AW(AW)) u_rd_b (
    .readnum(readnum_b), .regs(regs), .wr_ok(wr_ok), .writenum(writenum),
    .data_in(data_in), .data_out(data_out_b)
  );
endmodule
